// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT    = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_EXT  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  // Width of the channel index; never narrower than one bit.
  function automatic int unsigned stage_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module rst_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer_gen.sv
// Lock-gated, staggered reset release for NUM_CH domains with restart cause.
module rst_sequencer_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              system_clock,
  input  logic              system_reset_n,
  input  logic              ext_reset,
  input  logic              mmcm_locked,
  input  logic              sw_reset_req,
  output logic [NUM_CH-1:0] ch_reset,
  output logic              seq_done,
  output logic              busy,
  output logic [1:0]        reset_cause
);

  import rst_seq_pkg::*;

  localparam int unsigned       STG_W     = stage_w(NUM_CH);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]  LAST_STG  = STG_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE       = NUM_CH'(1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [STG_W-1:0] stage;
  logic [STG_W-1:0] next_stg;
  logic             ext_sync, lock_sync;
  logic             ext_prev, lock_prev;
  logic             ext_rise, lock_fall, restart;

  rst_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .clk   (system_clock),
    .rst_n (system_reset_n),
    .d     (ext_reset),
    .q     (ext_sync)
  );

  rst_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (system_clock),
    .rst_n (system_reset_n),
    .d     (mmcm_locked),
    .q     (lock_sync)
  );

  assign ext_rise  = ext_sync & ~ext_prev;
  assign lock_fall = ~lock_sync & lock_prev;
  assign restart   = (state != ASSERT) & (ext_rise | lock_fall | sw_reset_req);
  assign next_stg  = stage + 1'b1;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state       <= ASSERT;
      cnt         <= '0;
      stage       <= '0;
      ch_reset    <= '1;
      seq_done    <= 1'b0;
      busy        <= 1'b1;
      reset_cause <= CAUSE_POR;
      ext_prev    <= 1'b0;
      lock_prev   <= 1'b0;
    end else begin
      ext_prev  <= ext_sync;
      lock_prev <= lock_sync;
      if (restart) begin
        state       <= ASSERT;
        cnt         <= '0;
        stage       <= '0;
        ch_reset    <= '1;
        seq_done    <= 1'b0;
        busy        <= 1'b1;
        reset_cause <= ext_rise  ? CAUSE_EXT  :
                       lock_fall ? CAUSE_LOCK : CAUSE_SW;
      end else begin
        case (state)
          ASSERT: begin
            ch_reset <= '1;
            state    <= WAIT_LOCK;
          end
          WAIT_LOCK: begin
            if (lock_sync && !ext_sync) begin
              state <= HOLD;
              cnt   <= '0;
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt      <= '0;
              stage    <= '0;
              ch_reset <= ch_reset & ~ONE;
              // A single channel is fully released here, so RELEASE is skipped.
              if (NUM_CH == 1) begin
                state    <= RUN;
                seq_done <= 1'b1;
                busy     <= 1'b0;
              end else begin
                state <= RELEASE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == GAP_LAST) begin
              cnt      <= '0;
              stage    <= next_stg;
              ch_reset <= ch_reset & ~(ONE << next_stg);
              if (next_stg == LAST_STG) begin
                state    <= RUN;
                seq_done <= 1'b1;
                busy     <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            seq_done <= 1'b1;
            busy     <= 1'b0;
          end
          default: state <= ASSERT;
        endcase
      end
    end
  end

endmodule
